triad_decoder: RTL and testbench

- Decodes the serial comparator triad streams from the comparator chip into a 32-bit one-hot-per-distrip halfstrip image.
- Sits directly upstream of comparator_injector and drives its halfstrips[31:0] input, which is checked against compout_expect and the active halfstrip.
- One 3-bit triad FSM per distrip, 8 distrips × 4 halfstrips.
- Each decoded halfstrip is held for a programmable persistence window.

---
 rtl/triad_decoder.sv | 108 ++++++++++
 tb/tb_triad_decoder.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/triad_decoder.sv
// Serial comparator triad decoder: one 3-bit triad FSM per distrip, with each decoded halfstrip held persist+1 clocks.
// Define TRIAD_SKIP_CNT_EN to build the saturating 16-bit triad_skip_cnt; otherwise it is tied to 0.
module triad_decoder #(
  parameter int NDISTRIPS = 8,
  parameter int PERSIST_W = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NDISTRIPS-1:0]   triad_in,
  input  logic [PERSIST_W-1:0]   persist,
  input  logic                   skip_cnt_rst,
  output logic [4*NDISTRIPS-1:0] halfstrips,
  output logic [NDISTRIPS-1:0]   triad_skip,
  output logic [15:0]            triad_skip_cnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] STRIP = 2'd1;
  localparam logic [1:0] HSBIT = 2'd2;
  localparam logic [1:0] BUSY  = 2'd3;

  for (genvar d = 0; d < NDISTRIPS; d++) begin : g_distrip
    logic [1:0]           state_q, state_d;
    logic [PERSIST_W-1:0] cnt_q, cnt_d;
    logic                 strip_q, strip_d;
    logic                 hs_q, hs_d;
    logic [3:0]           hits_q, hits_d;
    logic                 skip_q, skip_d;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      strip_d = strip_q;
      hs_d    = hs_q;
      skip_d  = 1'b0;
      hits_d  = '0;
      // The hit register trails the FSM by one edge, so BUSY drives it.
      if (state_q == BUSY) hits_d[{strip_q, hs_q}] = 1'b1;
      case (state_q)
        IDLE: begin
          if (triad_in[d]) state_d = STRIP;
        end
        STRIP: begin
          strip_d = triad_in[d];
          state_d = HSBIT;
        end
        HSBIT: begin
          hs_d    = triad_in[d];
          cnt_d   = persist;
          state_d = BUSY;
        end
        default: begin
          skip_d = triad_in[d];
          if (cnt_q == '0) state_d = IDLE;
          else             cnt_d   = cnt_q - PERSIST_W'(1);
        end
      endcase
    end

    always_ff @(posedge clock) begin
      if (!reset) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        strip_q <= 1'b0;
        hs_q    <= 1'b0;
        hits_q  <= '0;
        skip_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        strip_q <= strip_d;
        hs_q    <= hs_d;
        hits_q  <= hits_d;
        skip_q  <= skip_d;
      end
    end

    assign halfstrips[4*d +: 4] = hits_q;
    assign triad_skip[d]        = skip_q;
  end

`ifdef TRIAD_SKIP_CNT_EN
  logic [15:0] skip_cnt_q, skip_cnt_d;
  logic [16:0] skip_sum;

  always_comb begin
    skip_sum = {1'b0, skip_cnt_q};
    for (int unsigned i = 0; i < NDISTRIPS; i++) begin
      skip_sum = skip_sum + 17'(triad_skip[i]);
    end
    if (skip_cnt_rst)     skip_cnt_d = '0;
    else if (skip_sum[16]) skip_cnt_d = '1;
    else                  skip_cnt_d = skip_sum[15:0];
  end

  always_ff @(posedge clock) begin
    if (!reset) skip_cnt_q <= '0;
    else        skip_cnt_q <= skip_cnt_d;
  end

  assign triad_skip_cnt = skip_cnt_q;
`else
  logic unused_skip_cnt_rst;
  assign unused_skip_cnt_rst = skip_cnt_rst;
  assign triad_skip_cnt      = '0;
`endif

endmodule

// File: tb/tb_triad_decoder.sv
// Directed self-checking bench for triad_decoder; expected skip counts follow TRIAD_SKIP_CNT_EN.
module tb_triad_decoder;

  logic        clock;
  logic        reset;
  logic [7:0]  triad_in;
  logic [3:0]  persist;
  logic        skip_cnt_rst;
  logic [31:0] halfstrips;
  logic [7:0]  triad_skip;
  logic [15:0] triad_skip_cnt;

  int unsigned n_checks;
  int unsigned n_pass;

`ifdef TRIAD_SKIP_CNT_EN
  localparam logic [15:0] CNT_ONE = 16'h0001;
  localparam logic [15:0] CNT_SAT = 16'hFFFF;
`else
  localparam logic [15:0] CNT_ONE = 16'h0000;
  localparam logic [15:0] CNT_SAT = 16'h0000;
`endif

  triad_decoder #(
    .NDISTRIPS(8),
    .PERSIST_W(4)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .triad_in      (triad_in),
    .persist       (persist),
    .skip_cnt_rst  (skip_cnt_rst),
    .halfstrips    (halfstrips),
    .triad_skip    (triad_skip),
    .triad_skip_cnt(triad_skip_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else             n_pass++;
  endtask

  // Drive one cycle of triad input, then sample just after the edge.
  task automatic step(input logic [7:0] tin);
    triad_in = tin;
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_checks     = 0;
    n_pass       = 0;
    reset        = 1'b0;
    triad_in     = '0;
    persist      = '0;
    skip_cnt_rst = 1'b0;

    // Reset state
    step(8'h00);
    step(8'hFF);
    chk("reset_hs",   halfstrips,     32'h0);
    chk("reset_skip", {24'h0, triad_skip}, 32'h0);
    chk("reset_cnt",  {16'h0, triad_skip_cnt}, 32'h0);
    reset = 1'b1;
    step(8'h00);

    // "1,0,1" on line 4, persist=0 -> bit 17 for one clock
    persist = 4'd0;
    step(8'h10);
    step(8'h00);
    step(8'h10);
    chk("t1_pre",  halfstrips, 32'h0);
    step(8'h00);
    chk("t1_hit",  halfstrips, 32'h0002_0000);
    step(8'h00);
    chk("t1_clr",  halfstrips, 32'h0);

    // "1,1,1" on line 0, persist=5 -> bit 3 for 6 clocks, skip 2 clocks in
    persist = 4'd5;
    step(8'h01);
    step(8'h01);
    step(8'h01);
    persist = 4'd0;
    step(8'h00);
    chk("t2_h1", halfstrips, 32'h8);
    step(8'h00);
    chk("t2_h2", halfstrips, 32'h8);
    step(8'h01);
    chk("t2_h3",   halfstrips, 32'h8);
    chk("t2_skip", {24'h0, triad_skip}, 32'h1);
    step(8'h00);
    chk("t2_h4",    halfstrips, 32'h8);
    chk("t2_skip0", {24'h0, triad_skip}, 32'h0);
    chk("t2_cnt",   {16'h0, triad_skip_cnt}, {16'h0, CNT_ONE});
    step(8'h00);
    chk("t2_h5", halfstrips, 32'h8);
    step(8'h00);
    chk("t2_h6", halfstrips, 32'h8);
    step(8'h00);
    chk("t2_clr", halfstrips, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step(8'h00);
      chk("t2_nohit", halfstrips, 32'h0);
    end
    chk("t2_cnt_hold", {16'h0, triad_skip_cnt}, {16'h0, CNT_ONE});

    // "1,1,0" on all lines simultaneously
    step(8'hFF);
    step(8'hFF);
    step(8'h00);
    step(8'h00);
    chk("t3_all", halfstrips, 32'h4444_4444);
    step(8'h00);
    chk("t3_clr", halfstrips, 32'h0);

    // Back-to-back on line 7: "1,0,0" then "1,1,1" at the first legal clock
    step(8'h80);
    step(8'h00);
    step(8'h00);
    step(8'h00);
    chk("t4_hit28", halfstrips, 32'h1000_0000);
    step(8'h80);
    chk("t4_gap",   halfstrips, 32'h0);
    chk("t4_noskip0", {24'h0, triad_skip}, 32'h0);
    step(8'h80);
    step(8'h80);
    chk("t4_noskip1", {24'h0, triad_skip}, 32'h0);
    step(8'h00);
    chk("t4_hit31", halfstrips, 32'h8000_0000);
    chk("t4_noskip2", {24'h0, triad_skip}, 32'h0);
    step(8'h00);
    chk("t4_clr", halfstrips, 32'h0);
    chk("t4_cnt", {16'h0, triad_skip_cnt}, {16'h0, CNT_ONE});

    // Reset mid-triad on line 2 aborts it
    step(8'h04);
    step(8'h01);
    reset = 1'b0;
    step(8'h04);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(8'h00);
      chk("t5_hs",   halfstrips, 32'h0);
      chk("t5_skip", {24'h0, triad_skip}, 32'h0);
    end
    chk("t5_cnt", {16'h0, triad_skip_cnt}, 32'h0);
    step(8'h04);
    step(8'h04);
    step(8'h04);
    step(8'h00);
    chk("t5_resume", halfstrips, 32'h0000_0800);
    step(8'h00);
    chk("t5_resume_clr", halfstrips, 32'h0);

    // Saturate the skip counter, then clear it
    persist = 4'd15;
    for (int i = 0; i < 11000; i++) begin
      step(8'hFF);
`ifndef TRIAD_SKIP_CNT_EN
      if (i % 1000 == 999) chk("t6_cnt_off", {16'h0, triad_skip_cnt}, 32'h0);
`endif
    end
    chk("t6_sat", {16'h0, triad_skip_cnt}, {16'h0, CNT_SAT});
    step(8'hFF);
    chk("t6_sat_hold", {16'h0, triad_skip_cnt}, {16'h0, CNT_SAT});
    skip_cnt_rst = 1'b1;
    step(8'h00);
    skip_cnt_rst = 1'b0;
    chk("t6_clr", {16'h0, triad_skip_cnt}, 32'h0);
    step(8'h00);
    chk("t6_clr_hold", {16'h0, triad_skip_cnt}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
